// File: rtl/AHB_package.sv
// ---------------------------------------------------------------------------
// AHB_package
// Shared AHB types for the address decoder and its built-in default slave:
//   htrans_type : address-phase transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_type  : slave response encoding (OKAY/ERROR/RETRY/SPLIT)
//   ds_state_t  : default-slave response state
// ---------------------------------------------------------------------------
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    DS_OKAY = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // A transfer only requests a slave when it is NONSEQ or SEQ.
  function automatic logic is_active(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_decoder_dp_if.sv
// ---------------------------------------------------------------------------
// ahb_decoder_dp_if
// Bus bundle between the AHB master side and the address decoder.
//   master modport : drives haddr/htrans/hready/hremap, observes decode results
//   slave  modport : decoder view (inputs address phase, outputs selects and
//                    default-slave response)
// ---------------------------------------------------------------------------
interface ahb_decoder_dp_if
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 3
) ();

  logic [AHB_ADDR_WIDTH-1:0] haddr;
  htrans_type                htrans;
  logic                      hready;
  logic                      hremap;
  logic [SLAVE_NUM-1:0]      hsel;
  logic [SLAVE_NUM-1:0]      hsel_dp;
  logic                      default_sel_dp;
  logic                      hready_def;
  hresp_type                 hresp_def;

  modport master (
    output haddr, htrans, hready, hremap,
    input  hsel, hsel_dp, default_sel_dp, hready_def, hresp_def
  );

  modport slave (
    input  haddr, htrans, hready, hremap,
    output hsel, hsel_dp, default_sel_dp, hready_def, hresp_def
  );

endinterface

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Built-in slave that answers transfers to unmapped addresses with the
// standard two-cycle AHB ERROR response; everything else gets zero-wait OKAY.
//   hclk, hreset_n : clock, asynchronous active-low reset
//   i_hready       : bus-wide hready (address-phase acceptance)
//   i_unmapped     : current address phase is NONSEQ/SEQ with no region hit
//   o_hready_def   : default slave hreadyout (registered)
//   o_hresp_def    : default slave hresp (registered)
// ---------------------------------------------------------------------------
module ahb_default_slave
  import AHB_package::*;
(
  input  logic      hclk,
  input  logic      hreset_n,
  input  logic      i_hready,
  input  logic      i_unmapped,
  output logic      o_hready_def,
  output hresp_type o_hresp_def
);

  ds_state_t r_state;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state      <= DS_OKAY;
      o_hready_def <= 1'b1;
      o_hresp_def  <= OKAY;
    end else begin
      case (r_state)
        // DS_OKAY and DS_ERR2 both sit at hready_def=1, so a new unmapped
        // request can be accepted from either and always starts a fresh ERR1.
        DS_OKAY, DS_ERR2: begin
          if (i_hready && i_unmapped) begin
            r_state      <= DS_ERR1;
            o_hready_def <= 1'b0;
            o_hresp_def  <= ERROR;
          end else begin
            r_state      <= DS_OKAY;
            o_hready_def <= 1'b1;
            o_hresp_def  <= OKAY;
          end
        end
        DS_ERR1: begin
          r_state      <= DS_ERR2;
          o_hready_def <= 1'b1;
          o_hresp_def  <= ERROR;
        end
        default: begin
          r_state      <= DS_OKAY;
          o_hready_def <= 1'b1;
          o_hresp_def  <= OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_decoder_dp.sv
// ---------------------------------------------------------------------------
// ahb_decoder_dp
// AHB address decoder with registered data-phase select and a built-in
// default slave for unmapped addresses.
//   hclk, hreset_n : clock, asynchronous active-low reset
//   bus (slave)    : haddr/htrans/hready/hremap in;
//                    hsel (comb, address phase), hsel_dp/default_sel_dp
//                    (registered, data phase), hready_def/hresp_def out
// Regions are inclusive [SLV_LOW[i], SLV_HIGH[i]]; the lowest index wins on
// overlap. With hremap=1 a region-0 hit is redirected to REMAP_SLV.
// ---------------------------------------------------------------------------
module ahb_decoder_dp
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 3,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] SLV_LOW =
    {32'h0000_2404, 32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] SLV_HIGH =
    {32'h0000_2AFF, 32'h0000_19FF, 32'h0000_03FF},
  parameter int REMAP_SLV = 1
) (
  input logic             hclk,
  input logic             hreset_n,
  ahb_decoder_dp_if.slave bus
);

  logic [SLAVE_NUM-1:0] w_match;
  logic [SLAVE_NUM-1:0] w_prio;
  logic [SLAVE_NUM-1:0] w_decode;
  logic                 w_active;
  logic                 w_any;
  logic                 w_unmapped;
  logic [SLAVE_NUM-1:0] r_hsel_dp;
  logic                 r_default_sel_dp;

  genvar gi;
  generate
    for (gi = 0; gi < SLAVE_NUM; gi++) begin : g_region
      assign w_match[gi] = (bus.haddr >= SLV_LOW[gi]) && (bus.haddr <= SLV_HIGH[gi]);
      // Lowest index wins: a region only claims the address if no lower one did.
      if (gi == 0) begin : g_first
        assign w_prio[gi] = w_match[gi];
      end else begin : g_rest
        assign w_prio[gi] = w_match[gi] & ~(|w_match[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    w_decode = w_prio;
    if (bus.hremap && w_prio[0]) begin
      w_decode[0]         = 1'b0;
      w_decode[REMAP_SLV] = 1'b1;
    end
  end

  assign w_active   = is_active(bus.htrans);
  assign w_any      = |w_match;
  assign w_unmapped = w_active & ~w_any;

  assign bus.hsel = w_active ? w_decode : '0;

  // Data-phase select follows the decode of every accepted phase, including
  // IDLE/BUSY, so the response mux always points at the slave that owns the
  // data phase (the default slave when nothing matched).
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_hsel_dp        <= '0;
      r_default_sel_dp <= 1'b0;
    end else if (bus.hready) begin
      r_hsel_dp        <= w_decode;
      r_default_sel_dp <= ~w_any;
    end
  end

  assign bus.hsel_dp        = r_hsel_dp;
  assign bus.default_sel_dp = r_default_sel_dp;

  ahb_default_slave u_default_slave (
    .hclk         (hclk),
    .hreset_n     (hreset_n),
    .i_hready     (bus.hready),
    .i_unmapped   (w_unmapped),
    .o_hready_def (bus.hready_def),
    .o_hresp_def  (bus.hresp_def)
  );

endmodule

// File: tb/tb_ahb_decoder_dp.sv
// ---------------------------------------------------------------------------
// tb_ahb_decoder_dp
// Directed bench for ahb_decoder_dp. A small reference model tracks the
// expected data-phase owner and the number of error-response cycles still
// pending; hready is built from the model's response mux (or forced low by
// a stall control). Outputs are compared on every falling edge, and literal
// expectations are checked 1 ns after each input update.
// ---------------------------------------------------------------------------
module tb_ahb_decoder_dp;
  import AHB_package::*;

  localparam logic [31:0] LO [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2404};
  localparam logic [31:0] HI [3] = '{32'h0000_03FF, 32'h0000_19FF, 32'h0000_2AFF};

  logic hclk;
  logic hreset_n;
  logic stall;

  ahb_decoder_dp_if #(.AHB_ADDR_WIDTH(32), .SLAVE_NUM(3)) bus ();

  ahb_decoder_dp #(.AHB_ADDR_WIDTH(32), .SLAVE_NUM(3)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [2:0] m_dp;
  logic       m_def;
  int         m_left;   // error-response cycles still to be presented (2,1,0)
  logic       m_hready;

  assign m_hready = stall ? 1'b0 : (m_def ? (m_left != 2) : 1'b1);
  assign bus.hready = m_hready;

  // Index of the slave owning addr (after remap), -1 when unmapped.
  function automatic int mdec(input logic [31:0] a, input logic rm);
    int idx;
    idx = -1;
    for (int i = 2; i >= 0; i--)
      if (a >= LO[i] && a <= HI[i]) idx = i;
    if (rm && idx == 0) idx = 1;
    return idx;
  endfunction

  function automatic logic [2:0] onehot(input int idx);
    return (idx < 0) ? 3'b000 : 3'(1 << idx);
  endfunction

  function automatic logic act(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge hclk or negedge hreset_n) begin : model
    int idx;
    int nl;
    if (!hreset_n) begin
      m_dp   <= 3'b000;
      m_def  <= 1'b0;
      m_left <= 0;
    end else begin
      idx = mdec(bus.haddr, bus.hremap);
      nl  = (m_left > 0) ? m_left - 1 : 0;
      if (m_hready && act(bus.htrans) && idx < 0) nl = 2;
      m_left <= nl;
      if (m_hready) begin
        m_dp  <= onehot(idx);
        m_def <= (idx < 0);
      end
    end
  end

  always @(negedge hclk) begin
    chk("cyc_hsel", bus.hsel,
        act(bus.htrans) ? onehot(mdec(bus.haddr, bus.hremap)) : 3'b000);
    chk("cyc_hsel_dp", bus.hsel_dp, m_dp);
    chk("cyc_default_sel_dp", bus.default_sel_dp, m_def);
    chk("cyc_hready_def", bus.hready_def, (m_left != 2));
    chk("cyc_hresp_def", bus.hresp_def, (m_left != 0) ? ERROR : OKAY);
  end

  task automatic drive(input logic [31:0] a, input htrans_type t, input logic rm, input logic st);
    @(posedge hclk);
    #2;
    bus.haddr  = a;
    bus.htrans = t;
    bus.hremap = rm;
    stall      = st;
    $display("txn haddr=%08h htrans=%s hremap=%0b stall=%0b", a, t.name(), rm, st);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    htrans_type  t;
    logic [2:0]  sel;
  } vec_t;

  vec_t bnd [8] = '{
    '{32'h0000_0FFF, NONSEQ, 3'b000},
    '{32'h0000_19FF, SEQ,    3'b010},
    '{32'h0000_1A00, NONSEQ, 3'b000},
    '{32'h0000_2403, SEQ,    3'b000},
    '{32'h0000_2404, NONSEQ, 3'b100},
    '{32'h0000_2B00, SEQ,    3'b000},
    '{32'h0000_1500, BUSY,   3'b000},
    '{32'h0000_0000, NONSEQ, 3'b001}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset_n   = 1'b0;
    stall      = 1'b0;
    bus.haddr  = 32'h0;
    bus.htrans = IDLE;
    bus.hremap = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hsel_dp", bus.hsel_dp, 3'b000);
    chk("rst_default_sel_dp", bus.default_sel_dp, 1'b0);
    chk("rst_hready_def", bus.hready_def, 1'b1);
    chk("rst_hresp_def", bus.hresp_def, OKAY);
    @(posedge hclk);
    #2 hreset_n = 1'b1;

    // Basic decode and inclusive bounds
    drive(32'h0000_1000, NONSEQ, 0, 0); chk("l_hsel_1000", bus.hsel, 3'b010);
    drive(32'h0000_2AFF, SEQ, 0, 0);
    chk("l_dp_1000", bus.hsel_dp, 3'b010);
    chk("l_def_1000", bus.default_sel_dp, 1'b0);
    chk("l_hsel_2AFF", bus.hsel, 3'b100);
    drive(32'h0000_03FF, SEQ, 0, 0);
    chk("l_hsel_03FF", bus.hsel, 3'b001);
    chk("l_dp_2AFF", bus.hsel_dp, 3'b100);

    // Unmapped NONSEQ: two-cycle ERROR
    drive(32'h0000_0800, NONSEQ, 0, 0);
    chk("l_hsel_0800", bus.hsel, 3'b000);
    chk("l_dp_03FF", bus.hsel_dp, 3'b001);
    drive(32'h0000_0000, IDLE, 0, 0);
    chk("l_err1_rdy", bus.hready_def, 1'b0);
    chk("l_err1_resp", bus.hresp_def, ERROR);
    chk("l_err1_def", bus.default_sel_dp, 1'b1);
    drive(32'h0000_0000, IDLE, 0, 0);
    chk("l_err2_rdy", bus.hready_def, 1'b1);
    chk("l_err2_resp", bus.hresp_def, ERROR);
    chk("l_err2_def", bus.default_sel_dp, 1'b1);

    // IDLE/BUSY to unmapped: zero-wait OKAY
    drive(32'h0000_0800, IDLE, 0, 0);
    chk("l_okay_rdy", bus.hready_def, 1'b1);
    chk("l_okay_resp", bus.hresp_def, OKAY);
    chk("l_idle_map_dp", bus.hsel_dp, 3'b001);
    drive(32'h0000_0800, BUSY, 0, 0);
    chk("l_idle_unm_rdy", bus.hready_def, 1'b1);
    chk("l_idle_unm_resp", bus.hresp_def, OKAY);
    chk("l_idle_unm_def", bus.default_sel_dp, 1'b1);

    // Back-to-back unmapped transfers
    drive(32'h0000_0800, NONSEQ, 0, 0);
    drive(32'h0000_3000, SEQ, 0, 0);    chk("l_b2b_a1", bus.hready_def, 1'b0);
    drive(32'h0000_3000, SEQ, 0, 0);    chk("l_b2b_a2", bus.hready_def, 1'b1);
    drive(32'h0000_1000, NONSEQ, 0, 0);
    chk("l_b2b_b1", bus.hready_def, 1'b0);
    chk("l_b2b_b1_resp", bus.hresp_def, ERROR);
    drive(32'h0000_1000, NONSEQ, 0, 0); chk("l_b2b_b2", bus.hready_def, 1'b1);

    // Remap
    drive(32'h0000_0010, NONSEQ, 1, 0);
    chk("l_remap_hsel", bus.hsel, 3'b010);
    chk("l_after_b2b_resp", bus.hresp_def, OKAY);
    chk("l_after_b2b_dp", bus.hsel_dp, 3'b010);
    drive(32'h0000_1000, NONSEQ, 1, 0); chk("l_remap_dp", bus.hsel_dp, 3'b010);

    // hready low holds the data-phase select
    drive(32'h0000_2404, NONSEQ, 0, 1); chk("l_stall_hsel", bus.hsel, 3'b100);
    drive(32'h0000_0000, NONSEQ, 0, 0); chk("l_stall_hold", bus.hsel_dp, 3'b010);
    drive(32'h0000_0000, IDLE, 0, 0);   chk("l_after_stall", bus.hsel_dp, 3'b001);

    // Asynchronous reset in the middle of an ERROR response
    drive(32'h0000_0800, NONSEQ, 0, 0);
    @(posedge hclk);
    #2;
    chk("l_pre_rst_rdy", bus.hready_def, 1'b0);
    hreset_n = 1'b0;
    #1;
    chk("l_arst_dp", bus.hsel_dp, 3'b000);
    chk("l_arst_def", bus.default_sel_dp, 1'b0);
    chk("l_arst_rdy", bus.hready_def, 1'b1);
    chk("l_arst_resp", bus.hresp_def, OKAY);
    repeat (2) @(posedge hclk);
    #2;
    hreset_n   = 1'b1;
    bus.haddr  = 32'h0000_1000;
    bus.htrans = NONSEQ;
    drive(32'h0000_0000, IDLE, 0, 0);
    chk("l_post_rst_dp", bus.hsel_dp, 3'b010);
    chk("l_post_rst_rdy", bus.hready_def, 1'b1);
    chk("l_post_rst_resp", bus.hresp_def, OKAY);

    // Boundary addresses around each region
    for (int i = 0; i < 8; i++) begin
      drive(bnd[i].a, bnd[i].t, 0, 0);
      chk($sformatf("l_bnd_%0d", i), bus.hsel, bnd[i].sel);
    end
    repeat (4) drive(32'h0000_0000, IDLE, 0, 0);

    @(posedge hclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
